// File: rtl/drop_sequencer_pkg.sv
// drop_sequencer_pkg: shared state encoding and widths for the hatch drop sequencer
package drop_sequencer_pkg;

    localparam int TIMER_W = 16;
    localparam int COUNT_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_OPENING = 3'd2,
        ST_HOLD    = 3'd3,
        ST_CLOSING = 3'd4,
        ST_DONE    = 3'd5,
        ST_FAULT   = 3'd6
    } state_t;

endpackage

// File: rtl/drop_sequencer_timer.sv
// drop_timer: loadable down-counter shared by every timed state; holds at zero
module drop_timer
    import drop_sequencer_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               i_load,
    input  logic [TIMER_W-1:0] i_value,
    output logic               o_zero
);

    logic [TIMER_W-1:0] r_cnt;

    // load wins over counting; the count parks at zero until the next load
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= i_value;
        else if (r_cnt != '0)
            r_cnt <= r_cnt - 1'b1;
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/drop_sequencer.sv
// drop_sequencer: debounced hatch open/hold/close sequencer with sensor timeouts; abort input under DROP_SEQ_ABORT_EN
module drop_sequencer
    import drop_sequencer_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES  = 4,
    parameter int unsigned HOLD_CYCLES    = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               drop_req,
    input  logic               drop_activated,
    input  logic               door_open_sense,
    input  logic               door_closed_sense,
    input  logic               fault_clr,
`ifdef DROP_SEQ_ABORT_EN
    input  logic               abort,
`endif
    output logic               hatch_open,
    output logic               busy,
    output logic               done,
    output logic               fault,
    output logic [COUNT_W-1:0] drop_count,
    output logic [2:0]         state_o
);

    localparam logic [TIMER_W-1:0] SETTLE_LD  = TIMER_W'(SETTLE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] HOLD_LD    = TIMER_W'(HOLD_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMEOUT_LD = TIMER_W'(TIMEOUT_CYCLES - 1);

    state_t               r_state;
    logic                 r_aborted;
    logic                 r_hatch;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_fault;
    logic [COUNT_W-1:0]   r_count;

    state_t               w_next;
    logic                 w_load;
    logic [TIMER_W-1:0]   w_load_val;
    logic                 w_zero;
    logic                 w_abort;
    logic                 w_abort_close;

`ifdef DROP_SEQ_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    assign w_abort_close = w_abort && (r_state == ST_OPENING || r_state == ST_HOLD);

    drop_timer u_timer (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_value (w_load_val),
        .o_zero  (w_zero)
    );

    // next state and timer reload; sensors take priority over an expiring timeout
    always_comb begin
        w_next     = r_state;
        w_load     = 1'b0;
        w_load_val = TIMEOUT_LD;
        case (r_state)
            ST_IDLE: begin
                if (drop_req && drop_activated) begin
                    w_next     = ST_SETTLE;
                    w_load     = 1'b1;
                    w_load_val = SETTLE_LD;
                end
            end
            ST_SETTLE: begin
                if (!drop_activated || w_abort)
                    w_next = ST_IDLE;
                else if (w_zero) begin
                    w_next = ST_OPENING;
                    w_load = 1'b1;
                end
            end
            ST_OPENING: begin
                if (w_abort) begin
                    w_next = ST_CLOSING;
                    w_load = 1'b1;
                end else if (door_open_sense) begin
                    w_next     = ST_HOLD;
                    w_load     = 1'b1;
                    w_load_val = HOLD_LD;
                end else if (w_zero)
                    w_next = ST_FAULT;
            end
            ST_HOLD: begin
                if (w_abort || w_zero) begin
                    w_next = ST_CLOSING;
                    w_load = 1'b1;
                end
            end
            ST_CLOSING: begin
                if (door_closed_sense)
                    w_next = r_aborted ? ST_IDLE : ST_DONE;
                else if (w_zero)
                    w_next = ST_FAULT;
            end
            ST_DONE:  w_next = ST_IDLE;
            ST_FAULT: w_next = (fault_clr && door_closed_sense) ? ST_IDLE : ST_FAULT;
            default:  w_next = ST_IDLE;
        endcase
    end

    // state register with outputs registered from the next state so they align with state_o
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_aborted <= 1'b0;
            r_hatch   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_fault   <= 1'b0;
            r_count   <= '0;
        end else begin
            r_state   <= w_next;
            r_aborted <= (w_next == ST_CLOSING) && (r_aborted || w_abort_close);
            r_hatch   <= (w_next == ST_OPENING) || (w_next == ST_HOLD);
            r_busy    <= (w_next != ST_IDLE) && (w_next != ST_FAULT);
            r_done    <= (w_next == ST_DONE);
            r_fault   <= (w_next == ST_FAULT);
            r_count   <= r_count + COUNT_W'(w_next == ST_DONE);
        end
    end

    assign hatch_open = r_hatch;
    assign busy       = r_busy;
    assign done       = r_done;
    assign fault      = r_fault;
    assign drop_count = r_count;
    assign state_o    = r_state;

endmodule

// File: tb/tb_drop_sequencer.sv
// tb_drop_sequencer: table-driven and randomized drop scenarios against an outcome-level model
module tb_drop_sequencer;

    localparam int S = 4;
    localparam int H = 16;
    localparam int T = 40;
    localparam int R_DONE  = 0;
    localparam int R_IDLE  = 1;
    localparam int R_FAULT = 2;
    localparam int R_HANG  = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic drop_req = 1'b0;
    logic act = 1'b1;
    logic open_s = 1'b0;
    logic closed_s = 1'b1;
    logic clr = 1'b0;
`ifdef DROP_SEQ_ABORT_EN
    logic abort_i = 1'b0;
`endif
    logic hatch, busy, done, fault;
    logic [7:0] cnt;
    logic [2:0] st;

    int total = 0;
    int bad = 0;
    int m_count = 0;

    typedef struct {
        int ract;
        int fall;
        int od;
        int cd;
        bit xreq;
        int res;
        int hc;
        int lat;
    } vec_t;

    vec_t tbl[10];

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    drop_sequencer #(.SETTLE_CYCLES(S), .HOLD_CYCLES(H), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst), .drop_req(drop_req), .drop_activated(act),
        .door_open_sense(open_s), .door_closed_sense(closed_s), .fault_clr(clr),
`ifdef DROP_SEQ_ABORT_EN
        .abort(abort_i),
`endif
        .hatch_open(hatch), .busy(busy), .done(done), .fault(fault),
        .drop_count(cnt), .state_o(st)
    );

    task automatic chk(input string n, input int a, input int e);
        total++;
        if (a != e) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", n, a, e);
        end
    endtask

    // outcome of one request derived from the timing rules: settle window, sensor deadlines, hold length
    function automatic void model(input int ract, input int fall, input int od, input int cd,
                                  output int res, output int hc, output int lat);
        lat = 0;
        if (ract == 0 || (fall >= 1 && fall <= S)) begin
            res = R_IDLE; hc = 0;
        end else if (od < 1 || od > T) begin
            res = R_FAULT; hc = T;
        end else if (cd < 1 || cd > T) begin
            res = R_FAULT; hc = od + H;
        end else begin
            res = R_DONE; hc = od + H; lat = S + od + H + cd;
        end
    endfunction

    // one request with a sensor model: door opens od cycles after command, closes cd cycles after release
    task automatic run_drop(input int ract, input int fall, input int od, input int cd, input bit xreq,
                            output int res, output int hc, output int dc, output int lat);
        int cyc, so, sc;
        bit was_open, fin;
        res = R_HANG; hc = 0; dc = 0; lat = 0; so = 0; sc = 0; was_open = 0; fin = 0; cyc = 0;
        @(negedge clk);
        drop_req = 1'b1;
        act = (ract != 0);
        @(negedge clk);
        drop_req = 1'b0;
        for (int i = 0; i < 400 && !fin; i++) begin
            if (hatch) hc++;
            if (done) begin dc++; lat = cyc; end
            if (fault) begin res = R_FAULT; fin = 1; end
            else if (!busy) begin res = (dc > 0) ? R_DONE : R_IDLE; fin = 1; end
            act = (ract != 0) && !(fall > 0 && cyc + 1 >= fall);
            if (hatch) begin was_open = 1; so++; sc = 0; end
            else if (was_open) sc++;
            open_s = hatch && od > 0 && so >= od;
            closed_s = !was_open || (cd > 0 && sc >= cd);
            drop_req = xreq && busy && ($urandom_range(0, 3) == 0);
            cyc++;
            @(negedge clk);
        end
        drop_req = 1'b0;
        act = 1'b1;
        open_s = 1'b0;
        closed_s = 1'b1;
    endtask

    task automatic clear_fault();
        @(negedge clk);
        clr = 1'b1;
        closed_s = 1'b0;
        @(negedge clk);
        chk("clr_ignored_fault", int'(fault), 1);
        closed_s = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("clr_ok_fault", int'(fault), 0);
        chk("clr_ok_state", int'(st), 0);
    endtask

    task automatic apply(input string n, input vec_t v);
        int res, hc, dc, lat;
        run_drop(v.ract, v.fall, v.od, v.cd, v.xreq, res, hc, dc, lat);
        if (v.res == R_DONE) m_count = (m_count + 1) % 256;
        chk({n, "_outcome"}, res, v.res);
        chk({n, "_hatch_cycles"}, hc, v.hc);
        chk({n, "_done_pulses"}, dc, (v.res == R_DONE) ? 1 : 0);
        if (v.res == R_DONE) chk({n, "_latency"}, lat, v.lat);
        chk({n, "_count"}, int'(cnt), m_count);
        if (res == R_FAULT) clear_fault();
    endtask

    task automatic wait_state(input int target, output bit found);
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            drop_req = 1'b0;
            open_s = hatch;
            closed_s = 1'b0;
            found = (int'(st) == target);
        end
    endtask

    initial begin
        vec_t v;
        bit found;
        int dc, res, hc, lat, nd, not_done;
        tbl[0] = '{1, 0, 2, 2, 0, R_DONE, 18, 24};
        tbl[1] = '{1, 2, 2, 2, 0, R_IDLE, 0, 0};
        tbl[2] = '{1, 0, 0, 2, 0, R_FAULT, 40, 0};
        tbl[3] = '{1, 4, 2, 2, 0, R_IDLE, 0, 0};
        tbl[4] = '{1, 5, 2, 2, 1, R_DONE, 18, 24};
        tbl[5] = '{1, 0, 40, 1, 1, R_DONE, 56, 61};
        tbl[6] = '{1, 0, 41, 1, 0, R_FAULT, 40, 0};
        tbl[7] = '{1, 0, 1, 40, 1, R_DONE, 17, 61};
        tbl[8] = '{1, 0, 3, 0, 0, R_FAULT, 19, 0};
        tbl[9] = '{0, 0, 2, 2, 0, R_IDLE, 0, 0};

        #12;
        chk("rst_hatch", int'(hatch), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_fault", int'(fault), 0);
        chk("rst_count", int'(cnt), 0);
        chk("rst_state", int'(st), 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) apply($sformatf("vec%0d", i), tbl[i]);

        for (int i = 0; i < 24; i++) begin
            v.ract = ($urandom_range(0, 9) != 0);
            v.fall = $urandom_range(0, 8);
            v.od = $urandom_range(0, 45);
            v.cd = $urandom_range(0, 45);
            v.xreq = $urandom_range(0, 1);
            model(v.ract, v.fall, v.od, v.cd, v.res, v.hc, v.lat);
            apply($sformatf("rnd%0d", i), v);
        end

        @(negedge clk);
        drop_req = 1'b1;
        wait_state(3, found);
        chk("hold_reached", int'(found), 1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_hatch", int'(hatch), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_fault", int'(fault), 0);
        chk("midrst_count", int'(cnt), 0);
        chk("midrst_state", int'(st), 0);
        m_count = 0;
        @(negedge clk);
        rst = 1'b0;
        open_s = 1'b0;
        closed_s = 1'b1;
        dc = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            dc += int'(done);
        end
        chk("midrst_no_done", dc, 0);
        chk("midrst_idle", int'(st), 0);

        nd = 0;
        not_done = 0;
        for (int i = 0; i < 256; i++) begin
            run_drop(1, 0, 1, 1, 1, res, hc, dc, lat);
            nd += dc;
            if (res != R_DONE) not_done++;
            if (i == 254) chk("wrap_count_255", int'(cnt), 255);
        end
        chk("wrap_count_0", int'(cnt), 0);
        chk("wrap_done_total", nd, 256);
        chk("wrap_all_done", not_done, 0);

`ifdef DROP_SEQ_ABORT_EN
        @(negedge clk);
        drop_req = 1'b1;
        wait_state(3, found);
        chk("abort_hold_reached", int'(found), 1);
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        open_s = 1'b0;
        chk("abort_closing", int'(st), 4);
        chk("abort_hatch", int'(hatch), 0);
        dc = int'(done);
        closed_s = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            dc += int'(done);
        end
        chk("abort_idle", int'(st), 0);
        chk("abort_no_done", dc, 0);
        chk("abort_count", int'(cnt), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
